apb_req_master: RTL
===================

APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 Parameter: APB_ADDR_WIDTH, 32, APB address width.
REQ-002 Parameter: APB_DATA_WIDTH, 32, APB data width.
REQ-003 Parameter: TIMEOUT_CYCLES, 255, max ACCESS wait cycles; used only with APB_REQ_MASTER_TIMEOUT_EN.
REQ-004 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  reset; synchronous and active-high.
REQ-006 req_i  input  1  request valid from the local initiator.
REQ-007 gnt_o  output  1  request accepted this cycle.
REQ-008 addr_i  input  APB_ADDR_WIDTH  request address.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 wdata_i  input  APB_DATA_WIDTH  write data.
REQ-011 rvalid_o  output  1  one-cycle response pulse.
REQ-012 rdata_o  output  APB_DATA_WIDTH  read data; valid with rvalid_o.
REQ-013 err_o  output  1  error flag; valid with rvalid_o.
REQ-014 paddr_o, pwdata_o, pwrite_o, psel_o, penable_o  outputs  APB_ADDR_WIDTH, APB_DATA_WIDTH, 1, 1, 1  APB3 master request signals to a single APB slave or node.
REQ-015 prdata_i, pready_i, pslverr_i  inputs  APB_DATA_WIDTH, 1, 1  APB3 slave response.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-017 In IDLE, gnt_o SHALL equal req_i combinationally; gnt_o SHALL be 0 in SETUP and ACCESS.
REQ-018 On grant, addr_i, we_i and wdata_i SHALL be registered into paddr_o, pwrite_o and pwdata_o; FSM -> SETUP.
REQ-019 SETUP SHALL last exactly one cycle with psel_o=1 and penable_o=0, then move to ACCESS.
REQ-020 ACCESS: psel_o=1, penable_o=1; paddr_o, pwrite_o and pwdata_o SHALL stay stable until completion.
REQ-021 ACCESS completes on the edge where pready_i=1: FSM -> IDLE, psel_o and penable_o -> 0.
REQ-022 One cycle after completion, rvalid_o=1 with err_o=pslverr_i; rdata_o=prdata_i for reads, 0 for writes.
REQ-023 Minimum latency SHALL be: grant at cycle 0, SETUP at 1, ACCESS at 2, rvalid_o at 3, next grant possible at 3.
REQ-024 rdata_o and err_o SHALL hold their last value while rvalid_o=0.
REQ-025 req_i arriving in SETUP or ACCESS SHALL NOT be granted until IDLE.

Reset
REQ-026 On rst_i=1 at a clock edge: FSM -> IDLE; psel_o, penable_o, pwrite_o, rvalid_o and err_o -> 0; paddr_o, pwdata_o and rdata_o -> 0.
REQ-027 Reset during SETUP or ACCESS SHALL abort the transfer with no rvalid_o pulse.

Configuration
REQ-028 With APB_REQ_MASTER_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with pready_i=0.
REQ-029 When that counter reaches TIMEOUT_CYCLES, the transfer SHALL abort: FSM -> IDLE, psel_o=penable_o=0, then rvalid_o=1, err_o=1, rdata_o=0.
REQ-030 The counter SHALL clear on entry to SETUP.
REQ-031 Without the macro, ACCESS SHALL wait on pready_i indefinitely, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-032 The state enum state_t (IDLE, SETUP, ACCESS) SHALL live in package apb_req_master_pkg.
REQ-033 apb_req_master_pkg SHALL also hold a packed request struct {addr, we, wdata}.
REQ-034 The timeout counter SHALL be sub-module apb_req_master_timer, instantiated only under APB_REQ_MASTER_TIMEOUT_EN.

Verification
REQ-035 Write, pready_i=1 immediately: req_i=1, we_i=1, addr_i=0x1A10_0004, wdata_i=0xDEAD_BEEF -> gnt_o at cycle 0, SETUP at 1, ACCESS at 2, rvalid_o=1 at 3, err_o=0, rdata_o=0.
REQ-036 Read with 3 wait states: pready_i=1 on the 4th ACCESS cycle, prdata_i=0x1234_5678 -> paddr_o stable for all 5 SETUP+ACCESS cycles; rvalid_o=1 with rdata_o=0x1234_5678.
REQ-037 Slave error: pslverr_i=1 with pready_i=1 on a read -> rvalid_o=1, err_o=1.
REQ-038 Back-to-back: req_i held high for two requests -> second gnt_o exactly at cycle 3; no overlap of psel_o between transfers.
REQ-039 Reset mid-ACCESS: rst_i=1 at cycle 2 -> psel_o=penable_o=0 at cycle 3; no rvalid_o pulse.
REQ-040 Timeout (macro defined, TIMEOUT_CYCLES=4): pready_i held 0 -> abort after 4 ACCESS cycles; rvalid_o=1, err_o=1, rdata_o=0.

Source files
------------

// File: rtl/apb_req_master_pkg.sv
// Shared types for the APB3 request master: FSM state encoding and captured request.
// The request struct fixes the widest supported address/data; the top casts into it.
package apb_req_master_pkg;

   localparam int REQ_ADDR_WIDTH = 32;
   localparam int REQ_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   typedef struct packed {
      logic [REQ_ADDR_WIDTH-1:0] addr;
      logic                      we;
      logic [REQ_DATA_WIDTH-1:0] wdata;
   } req_t;

endpackage

// File: rtl/apb_req_master_if.sv
// Bundles the local request/response handshake and the APB3 master port.
// master: the request master's view; slave: the initiator/APB-slave environment view.
interface apb_req_master_if #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
);
   logic                      req_i;
   logic                      gnt_o;
   logic [APB_ADDR_WIDTH-1:0] addr_i;
   logic                      we_i;
   logic [APB_DATA_WIDTH-1:0] wdata_i;
   logic                      rvalid_o;
   logic [APB_DATA_WIDTH-1:0] rdata_o;
   logic                      err_o;

   logic [APB_ADDR_WIDTH-1:0] paddr_o;
   logic [APB_DATA_WIDTH-1:0] pwdata_o;
   logic                      pwrite_o;
   logic                      psel_o;
   logic                      penable_o;
   logic [APB_DATA_WIDTH-1:0] prdata_i;
   logic                      pready_i;
   logic                      pslverr_i;

   modport master (
      input  req_i, addr_i, we_i, wdata_i, prdata_i, pready_i, pslverr_i,
      output gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
   );

   modport slave (
      output req_i, addr_i, we_i, wdata_i, prdata_i, pready_i, pslverr_i,
      input  gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
   );
endinterface

// File: rtl/apb_req_master_timer.sv
// Counts ACCESS wait cycles; expired fires combinationally on the TIMEOUT_CYCLES-th wait.
// Cleared when a new transfer is granted (entry to SETUP).
module apb_req_master_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // The cycle that would make the count reach the limit is the last ACCESS cycle.
   assign expired = inc && (cnt_q == LAST);
endmodule

// File: rtl/apb_req_master.sv
// Single-outstanding APB3 master: grant in IDLE, SETUP 1 cycle, ACCESS until pready, rvalid one cycle later.
// Optional ACCESS timeout under APB_REQ_MASTER_TIMEOUT_EN aborts with err=1.
module apb_req_master
   import apb_req_master_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   apb_req_master_if.master bus
);
   state_t                    state_q, state_d;
   req_t                      req_q;
   logic                      gnt;
   logic                      done;
   logic                      abort;
   logic                      timeout;
   logic                      rvalid_q;
   logic                      err_q;
   logic [APB_DATA_WIDTH-1:0] rdata_q;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
   apb_req_master_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk_i),
      .rst     (rst_i),
      .clr     (gnt),
      .inc     ((state_q == ACCESS) && !bus.pready_i),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt     = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            gnt = bus.req_i;
            if (bus.req_i) state_d = SETUP;
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (bus.pready_i) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (timeout) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         req_q    <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (gnt) begin
            req_q.addr  <= REQ_ADDR_WIDTH'(bus.addr_i);
            req_q.we    <= bus.we_i;
            req_q.wdata <= REQ_DATA_WIDTH'(bus.wdata_i);
         end
         rvalid_q <= done || abort;
         // rdata/err only move on a response so they hold between pulses.
         if (done) begin
            err_q   <= bus.pslverr_i;
            rdata_q <= req_q.we ? '0 : bus.prdata_i;
         end else if (abort) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end
      end
   end

   assign bus.gnt_o     = gnt;
   assign bus.psel_o    = (state_q == SETUP) || (state_q == ACCESS);
   assign bus.penable_o = (state_q == ACCESS);
   assign bus.paddr_o   = APB_ADDR_WIDTH'(req_q.addr);
   assign bus.pwrite_o  = req_q.we;
   assign bus.pwdata_o  = APB_DATA_WIDTH'(req_q.wdata);
   assign bus.rvalid_o  = rvalid_q;
   assign bus.err_o     = err_q;
   assign bus.rdata_o   = rdata_q;
endmodule
